// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-port arbiter for the shared instruction/data memory. Port C is the
// multicycle CPU, port D the debug/loader master. Each port issues single-beat
// read/write transactions over a req/done handshake; the arbiter latches the
// winning request, drives the memory port until m_ready (or a wait-count
// timeout), then pulses the owner's done/err for one cycle.
//
// Optional feature macro: MEM_PORT_ARB_RR_EN
//   defined   -> round-robin priority on contested arbitration
//   undefined -> fixed priority, CPU wins contested arbitration
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    // CPU port
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_done,
    output logic              c_err,
    // Debug port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    // Memory port
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    // Current / last grant: 0 = CPU, 1 = debug
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The wait counter is 8 bits wide (MAX_WAIT <= 255); the increment is
    // computed one bit wider so the comparison never wraps.
    localparam logic [8:0] MAX_WAIT_C = 9'(MAX_WAIT);

    state_t     state_r;
    logic [7:0] wait_cnt_r;

    logic       grant_d_s;
    logic [8:0] wait_next_s;
    logic       timeout_s;

    // Pick the winning port from the current requests (used only in IDLE).
    always_comb begin
        grant_d_s = 1'b0;
        if (c_req && d_req) begin
`ifdef MEM_PORT_ARB_RR_EN
            // Contested: the port that was not granted last time wins.
            grant_d_s = ~owner;
`else
            // Contested: the CPU always wins.
            grant_d_s = 1'b0;
`endif
        end else if (d_req) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Next wait count and timeout detection for the ACCESS state.
    always_comb begin
        wait_next_s = {1'b0, wait_cnt_r} + 9'd1;
        if (wait_next_s >= MAX_WAIT_C) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Arbitration FSM with all memory-port and response outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
            owner      <= 1'b0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            c_rdata    <= '0;
            d_rdata    <= '0;
            c_done     <= 1'b0;
            c_err      <= 1'b0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    c_done <= 1'b0;
                    c_err  <= 1'b0;
                    d_done <= 1'b0;
                    d_err  <= 1'b0;
                    if (c_req || d_req) begin
                        owner      <= grant_d_s;
                        m_en       <= 1'b1;
                        m_we       <= grant_d_s ? d_we    : c_we;
                        m_addr     <= grant_d_s ? d_addr  : c_addr;
                        m_wdata    <= grant_d_s ? d_wdata : c_wdata;
                        wait_cnt_r <= 8'd0;
                        state_r    <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                ACCESS: begin
                    if (m_ready) begin
                        // Completion beats a timeout landing on the same cycle.
                        if (!m_we) begin
                            if (owner) begin
                                d_rdata <= m_rdata;
                            end else begin
                                c_rdata <= m_rdata;
                            end
                        end
                        c_done  <= ~owner;
                        d_done  <= owner;
                        c_err   <= 1'b0;
                        d_err   <= 1'b0;
                        m_en    <= 1'b0;
                        m_we    <= 1'b0;
                        state_r <= RESP;
                    end else if (timeout_s) begin
                        // Abort: flag the owner, leave its read data untouched.
                        wait_cnt_r <= wait_next_s[7:0];
                        c_done     <= ~owner;
                        d_done     <= owner;
                        c_err      <= ~owner;
                        d_err      <= owner;
                        m_en       <= 1'b0;
                        m_we       <= 1'b0;
                        state_r    <= RESP;
                    end else begin
                        wait_cnt_r <= wait_next_s[7:0];
                        state_r    <= ACCESS;
                    end
                end

                RESP: begin
                    c_done  <= 1'b0;
                    c_err   <= 1'b0;
                    d_done  <= 1'b0;
                    d_err   <= 1'b0;
                    m_en    <= 1'b0;
                    m_we    <= 1'b0;
                    state_r <= IDLE;
                end

                default: begin
                    c_done  <= 1'b0;
                    c_err   <= 1'b0;
                    d_done  <= 1'b0;
                    d_err   <= 1'b0;
                    m_en    <= 1'b0;
                    m_we    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed testbench for mem_port_arbiter with hand-computed expectations.
// Honours MEM_PORT_ARB_RR_EN for the contested-arbitration grant order.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              c_req, c_we, d_req, d_we;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [DATA_W-1:0] c_wdata, d_wdata;
    logic [DATA_W-1:0] c_rdata, d_rdata;
    logic              c_done, c_err, d_done, d_err;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              owner;

    int vec_cnt     = 0;
    int miscmp_cnt  = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_done(c_done), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .owner(owner)
    );

    // Free-running clock, active edge at posedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one transaction from the point where req is already driven.
    // m_ready is raised during ACCESS cycle number ready_at (0 = never).
    // Returns at the negedge of the cycle where a done pulse is visible.
    task automatic run_access(input int ready_at, output int en_cnt, output int we_cnt,
                              output logic [31:0] last_addr, output logic [31:0] last_wdata,
                              output logic got_done);
        en_cnt = 0; we_cnt = 0; got_done = 1'b0;
        last_addr = 32'h0; last_wdata = 32'h0;
        for (int k = 0; k < 40 && !got_done; k++) begin
            @(negedge clk);
            if (c_done || d_done) begin
                got_done = 1'b1;
            end else begin
                if (m_en) begin
                    en_cnt++;
                    if (m_we) we_cnt++;
                    last_addr  = m_addr;
                    last_wdata = m_wdata;
                end
                m_ready = (m_en && en_cnt == ready_at);
            end
        end
        m_ready = 1'b0;
    endtask

    int          en_cnt, we_cnt;
    logic [31:0] l_addr, l_wdata;
    logic        got_done;
    logic        exp_grant [4];
    int          pulses, bad_pos, d_pulses;

    initial begin
`ifdef MEM_PORT_ARB_RR_EN
        exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        m_rdata = 32'h0; m_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_m_en", {31'd0, m_en}, 32'd0);
        check_val("rst_m_addr", m_addr, 32'h0);
        check_val("rst_done", {30'd0, c_done, d_done}, 32'd0);
        check_val("rst_owner", {31'd0, owner}, 32'd0);
        check_val("rst_c_rdata", c_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: CPU read, immediate m_ready
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40; m_rdata = 32'hDEADBEEF;
        run_access(1, en_cnt, we_cnt, l_addr, l_wdata, got_done);
        check_val("t1_done_seen", {31'd0, got_done}, 32'd1);
        check_val("t1_en_cycles", en_cnt, 32'd1);
        check_val("t1_we_cycles", we_cnt, 32'd0);
        check_val("t1_m_addr", l_addr, 32'h40);
        check_val("t1_c_done", {31'd0, c_done}, 32'd1);
        check_val("t1_c_err", {31'd0, c_err}, 32'd0);
        check_val("t1_d_done", {31'd0, d_done}, 32'd0);
        check_val("t1_c_rdata", c_rdata, 32'hDEADBEEF);
        check_val("t1_m_en_resp", {31'd0, m_en}, 32'd0);
        c_req = 1'b0;
        @(negedge clk);
        check_val("t1_done_pulse", {31'd0, c_done}, 32'd0);

        // 2: debug write, m_ready after 3 wait cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
        m_rdata = 32'hCAFEF00D;
        run_access(4, en_cnt, we_cnt, l_addr, l_wdata, got_done);
        check_val("t2_done_seen", {31'd0, got_done}, 32'd1);
        check_val("t2_en_cycles", en_cnt, 32'd4);
        check_val("t2_we_cycles", we_cnt, 32'd4);
        check_val("t2_m_addr", l_addr, 32'h100);
        check_val("t2_m_wdata", l_wdata, 32'h12345678);
        check_val("t2_d_done", {31'd0, d_done}, 32'd1);
        check_val("t2_d_err", {31'd0, d_err}, 32'd0);
        check_val("t2_c_done", {31'd0, c_done}, 32'd0);
        check_val("t2_d_rdata", d_rdata, 32'h0);
        check_val("t2_owner", {31'd0, owner}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check_val("t2_done_pulse", {31'd0, d_done}, 32'd0);

        // 3a: CPU read timeout
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h80; m_rdata = 32'h55555555;
        run_access(0, en_cnt, we_cnt, l_addr, l_wdata, got_done);
        check_val("t3a_done_seen", {31'd0, got_done}, 32'd1);
        check_val("t3a_en_cycles", en_cnt, 32'd15);
        check_val("t3a_c_done", {31'd0, c_done}, 32'd1);
        check_val("t3a_c_err", {31'd0, c_err}, 32'd1);
        check_val("t3a_c_rdata", c_rdata, 32'hDEADBEEF);
        check_val("t3a_owner", {31'd0, owner}, 32'd0);
        c_req = 1'b0;
        @(negedge clk);
        check_val("t3a_err_pulse", {31'd0, c_err}, 32'd0);

        // 3b: m_ready on the 15th ACCESS cycle wins over timeout
        c_req = 1'b1; m_rdata = 32'h0BADCAFE;
        run_access(15, en_cnt, we_cnt, l_addr, l_wdata, got_done);
        check_val("t3b_done_seen", {31'd0, got_done}, 32'd1);
        check_val("t3b_en_cycles", en_cnt, 32'd15);
        check_val("t3b_c_err", {31'd0, c_err}, 32'd0);
        check_val("t3b_c_rdata", c_rdata, 32'h0BADCAFE);
        c_req = 1'b0;
        @(negedge clk);

        // 4: contested arbitration, both ports held for 4 transactions
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        m_rdata = 32'h00000A0A;
        for (int t = 0; t < 4; t++) begin
            run_access(1, en_cnt, we_cnt, l_addr, l_wdata, got_done);
            check_val($sformatf("t4_done_seen%0d", t), {31'd0, got_done}, 32'd1);
            check_val($sformatf("t4_grant%0d", t), {30'd0, c_done, d_done},
                      exp_grant[t] ? 32'd1 : 32'd2);
            check_val($sformatf("t4_owner%0d", t), {31'd0, owner}, {31'd0, exp_grant[t]});
            check_val($sformatf("t4_addr%0d", t), l_addr, exp_grant[t] ? 32'h20 : 32'h10);
        end
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // 5: reset during 2nd ACCESS cycle of a CPU write
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h200; c_wdata = 32'hA5A5A5A5;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("t5_m_en_before", {31'd0, m_en}, 32'd1);
        check_val("t5_m_we_before", {31'd0, m_we}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("t5_m_en_async", {31'd0, m_en}, 32'd0);
        check_val("t5_m_we_async", {31'd0, m_we}, 32'd0);
        c_req = 1'b0; c_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("t5_no_done", {30'd0, c_done, d_done}, 32'd0);
        check_val("t5_owner", {31'd0, owner}, 32'd0);
        check_val("t5_c_rdata", c_rdata, 32'h0);
        check_val("t5_d_rdata", d_rdata, 32'h0);
        check_val("t5_m_en_idle", {31'd0, m_en}, 32'd0);

        // 6: back-to-back CPU reads with m_ready always 1
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h300; m_rdata = 32'h13572468;
        m_ready = 1'b1;
        pulses = 0; bad_pos = 0; d_pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (c_done) begin
                pulses++;
                if (k % 3 != 2) bad_pos++;
            end
            if (d_done) d_pulses++;
        end
        c_req = 1'b0; m_ready = 1'b0;
        check_val("t6_pulses", pulses, 32'd8);
        check_val("t6_bad_pos", bad_pos, 32'd0);
        check_val("t6_d_pulses", d_pulses, 32'd0);
        check_val("t6_c_rdata", c_rdata, 32'h13572468);
        @(negedge clk);
        @(negedge clk);
        check_val("t6_idle_m_en", {31'd0, m_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
